// File: rtl/shift_add_mult_ctrl.sv
// 4x4 unsigned shift-and-add multiplier sequencing a fourbit_adder.
// One conditional add plus one right shift per multiplier bit.
module fourbit_adder (
  input  logic A0,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  input  logic B0,
  input  logic B1,
  input  logic B2,
  input  logic B3,
  input  logic Cin,
  output logic S0,
  output logic S1,
  output logic S2,
  output logic S3,
  output logic Cout
);
  logic c1, c2, c3;

  assign S0   = A0 ^ B0 ^ Cin;
  assign c1   = (A0 & B0) | (Cin & (A0 ^ B0));
  assign S1   = A1 ^ B1 ^ c1;
  assign c2   = (A1 & B1) | (c1 & (A1 ^ B1));
  assign S2   = A2 ^ B2 ^ c2;
  assign c3   = (A2 & B2) | (c2 & (A2 ^ B2));
  assign S3   = A3 ^ B3 ^ c3;
  assign Cout = (A3 & B3) | (c3 & (A3 ^ B3));
endmodule

module shift_add_mult_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] multiplicand,
  input  logic [3:0] multiplier,
  output logic       busy,
  output logic       done,
  output logic [7:0] product
);
  typedef enum logic [1:0] {
    IDLE, ADD, SHIFT, DONE
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] m_q, m_d;
  logic [3:0] a_q, a_d;
  logic [3:0] q_q, q_d;
  logic       c_q, c_d;
  logic [1:0] cnt_q, cnt_d;
  logic [7:0] prod_q, prod_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [3:0] sum;
  logic       cout;

  fourbit_adder u_add (
    .A0   (a_q[0]),
    .A1   (a_q[1]),
    .A2   (a_q[2]),
    .A3   (a_q[3]),
    .B0   (m_q[0]),
    .B1   (m_q[1]),
    .B2   (m_q[2]),
    .B3   (m_q[3]),
    .Cin  (1'b0),
    .S0   (sum[0]),
    .S1   (sum[1]),
    .S2   (sum[2]),
    .S3   (sum[3]),
    .Cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      a_q     <= a_d;
      q_q     <= q_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    a_d     = a_q;
    q_d     = q_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
        end
      end
      ADD: begin
        if (q_q[0]) {c_d, a_d} = {cout, sum};
        else        {c_d, a_d} = {1'b0, a_q};
        state_d = SHIFT;
      end
      SHIFT: begin
        // Carry shifts into A's MSB so no add overflow is lost.
        c_d = 1'b0;
        a_d = {c_q, a_q[3:1]};
        q_d = {a_q[0], q_q[3:1]};
        if (cnt_q == 2'd3) begin
          prod_d  = {a_d, q_d};
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 2'd1;
          state_d = ADD;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;
endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl.
// Driver queues expected products; monitor checks each done pulse.
module tb_shift_add_mult_ctrl;
  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  typedef struct {
    logic [7:0] prod;
    int         due;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   checks;
  int   errors;
  logic prev_done;

  shift_add_mult_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_done) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL busy_fall: busy=%b want 0", busy);
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL spurious_done: product=%h at cycle %0d",
                   product, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (product !== e.prod) begin
            errors++;
            $display("FAIL product: got %h want %h", product, e.prod);
          end
          checks++;
          if (cyc != e.due) begin
            errors++;
            $display("FAIL latency: done at %0d want %0d", cyc, e.due);
          end
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%b want 0", busy);
    end
  endtask

  task automatic mul(input logic [3:0] a, input logic [3:0] b,
                     input logic [7:0] want);
    exp_t e;
    wait_idle();
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    e.prod = want;
    e.due  = cyc + 1 + 8;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise: busy=%b want 1", busy);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 3;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy: got %b want 0", busy);
    end
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done: got %b want 0", done);
    end
    if (product !== 8'h00) begin
      errors++;
      $display("FAIL rst_product: got %h want 00", product);
    end
    rst = 1'b0;

    mul(4'h5, 4'h3, 8'h0F);
    mul(4'hF, 4'hF, 8'hE1);
    mul(4'h0, 4'hF, 8'h00);
    mul(4'hA, 4'h6, 8'h3C);
    drain();

    // Mid-operation start must be ignored.
    mul(4'h7, 4'h9, 8'h3F);
    repeat (2) @(negedge clk);
    multiplicand = 4'h1;
    multiplier   = 4'h1;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mul(4'h1, 4'h1, 8'h01);
    drain();

    // Reset during the fourth busy cycle aborts the operation.
    wait_idle();
    multiplicand = 4'hC;
    multiplier   = 4'hD;
    start        = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy: got %b want 0", busy);
    end
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_done: got %b want 0", done);
    end
    if (product !== 8'h00) begin
      errors++;
      $display("FAIL abort_product: got %h want 00", product);
    end
    repeat (12) @(negedge clk);
    mul(4'h2, 4'h3, 8'h06);
    drain();

    // Held start: back-to-back, done pulses 10 cycles apart.
    begin
      exp_t e;
      wait_idle();
      multiplicand = 4'h3;
      multiplier   = 4'h4;
      start        = 1'b1;
      e.prod = 8'h0C;
      e.due  = cyc + 1 + 8;
      exp_q.push_back(e);
      e.prod = 8'h2A;
      e.due  = cyc + 1 + 18;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      multiplicand = 4'h6;
      multiplier   = 4'h7;
      repeat (10) @(posedge clk);
      #1;
      start = 1'b0;
    end
    drain();

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        mul(a[3:0], b[3:0], 8'(a * b));
      end
    end
    drain();
    repeat (15) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
